// File: rtl/fetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, reads one instruction per cycle
// from a combinational instruction memory and buffers {pc, instr} pairs for decode.
module fetch_queue #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 4,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   output logic [WIDTH-1:0] imem_addr,
   input  logic [WIDTH-1:0] imem_instr,
   input  logic             redirect,
   input  logic [WIDTH-1:0] redirect_pc,
   input  logic             id_stall,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_pc,
   output logic [WIDTH-1:0] out_instr,
   output logic [PTR_W:0]   count
);

   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic [WIDTH-1:0] mem_pc    [DEPTH];
   logic [WIDTH-1:0] mem_instr [DEPTH];
   logic             pop, push;

   // A full queue may still push when the head leaves in the same cycle.
   assign pop  = (count_q != '0) & ~id_stall & ~redirect;
   assign push = ~redirect & ((count_q < FULL_CNT) | pop);

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      if (redirect) begin
         fetch_pc_d = redirect_pc;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (push) begin
            wr_ptr_d   = wr_ptr_q + PTR_W'(1);
            fetch_pc_d = fetch_pc_q + WIDTH'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_pc_q <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
      end
   end

   // Storage carries no reset; validity is tracked entirely by count_q.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_pc[wr_ptr_q]    <= fetch_pc_q;
         mem_instr[wr_ptr_q] <= imem_instr;
      end
   end

   assign imem_addr = fetch_pc_q;
   assign out_valid = (count_q != '0);
   assign out_pc    = mem_pc[rd_ptr_q];
   assign out_instr = mem_instr[rd_ptr_q];
   assign count     = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: fill/steady-state, stall-to-full, full push+pop,
// redirect flush, PC wrap and asynchronous reset mid-operation.
module tb_fetch_queue;

   logic        clk = 1'b0;
   logic        reset;
   logic [11:0] imem_addr;
   logic [11:0] imem_instr;
   logic        redirect;
   logic [11:0] redirect_pc;
   logic        id_stall;
   logic        out_valid;
   logic [11:0] out_pc;
   logic [11:0] out_instr;
   logic [2:0]  count;

   int n_tests = 0;
   int n_fail  = 0;

   fetch_queue #(.WIDTH(12), .DEPTH(4), .PTR_W(2)) dut (
      .clk         (clk),
      .reset       (reset),
      .imem_addr   (imem_addr),
      .imem_instr  (imem_instr),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .id_stall    (id_stall),
      .out_valid   (out_valid),
      .out_pc      (out_pc),
      .out_instr   (out_instr),
      .count       (count)
   );

   always #5 clk = ~clk;

   assign imem_instr = imem_addr ^ 12'hA5A;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_tests++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   // Advance one edge and land on the following falling edge for sampling.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk_head(input string tag, input logic [11:0] pc, input logic [2:0] cnt);
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_pc"},    32'(out_pc),    32'(pc));
      chk({tag, "_instr"}, 32'(out_instr), 32'(pc ^ 12'hA5A));
      chk({tag, "_count"}, 32'(count),     32'(cnt));
   endtask

   initial begin
      reset       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 12'h000;
      id_stall    = 1'b0;
      step();
      step();
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_count", 32'(count),     32'd0);
      chk("rst_addr",  32'(imem_addr), 32'd0);

      // 1: steady state from empty, one in one out
      reset = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         chk_head($sformatf("t1_%0d", k), 12'(k), 3'd1);
      end
      chk("t1_addr", 32'(imem_addr), 32'h004);

      // 2: stall fills the queue, fetch freezes at head+4
      id_stall = 1'b1;
      for (int j = 1; j <= 8; j++) begin
         step();
         chk($sformatf("t2_count_%0d", j), 32'(count), 32'((j + 1 > 4) ? 4 : j + 1));
         chk($sformatf("t2_head_%0d", j),  32'(out_pc), 32'h003);
      end
      chk("t2_addr", 32'(imem_addr), 32'h007);

      // 3: full queue, single unstalled cycle: pop and push together
      id_stall = 1'b0;
      step();
      chk_head("t3", 12'h004, 3'd4);
      chk("t3_addr", 32'(imem_addr), 32'h008);
      for (int k = 5; k < 8; k++) begin
         step();
         chk_head($sformatf("t2r_%0d", k), 12'(k), 3'd4);
      end

      // 4: build 3 entries at 0x200, then redirect to 0x080
      redirect    = 1'b1;
      redirect_pc = 12'h200;
      step();
      redirect = 1'b0;
      chk("t4a_valid", 32'(out_valid), 32'd0);
      chk("t4a_count", 32'(count),     32'd0);
      step();
      chk_head("t4a_first", 12'h200, 3'd1);
      id_stall = 1'b1;
      step();
      step();
      chk_head("t4a_fill", 12'h200, 3'd3);
      id_stall    = 1'b0;
      redirect    = 1'b1;
      redirect_pc = 12'h080;
      step();
      redirect = 1'b0;
      chk("t4_valid", 32'(out_valid), 32'd0);
      chk("t4_count", 32'(count),     32'd0);
      chk("t4_addr",  32'(imem_addr), 32'h080);
      step();
      chk_head("t4_first", 12'h080, 3'd1);
      step();
      chk_head("t4_next", 12'h081, 3'd1);

      // 5: PC wrap through 0xFFF
      redirect    = 1'b1;
      redirect_pc = 12'hFFE;
      step();
      redirect = 1'b0;
      chk("t5_valid", 32'(out_valid), 32'd0);
      step();
      chk_head("t5_ffe", 12'hFFE, 3'd1);
      step();
      chk_head("t5_fff", 12'hFFF, 3'd1);
      step();
      chk_head("t5_000", 12'h000, 3'd1);
      step();
      chk_head("t5_001", 12'h001, 3'd1);

      // 6: async reset with 3 entries queued
      id_stall = 1'b1;
      step();
      step();
      chk("t6_pre_count", 32'(count), 32'd3);
      #2;
      reset = 1'b0;
      #1;
      chk("t6_valid", 32'(out_valid), 32'd0);
      chk("t6_count", 32'(count),     32'd0);
      chk("t6_addr",  32'(imem_addr), 32'd0);
      id_stall = 1'b0;
      step();
      reset = 1'b1;
      step();
      chk_head("t6_first", 12'h000, 3'd1);
      step();
      chk_head("t6_next", 12'h001, 3'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
